// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial input, recovers each frame with a
// cycle counter, and reports the received byte or a framing error.
module uart_rx #(
  parameter int Mhz       = 125,
  parameter int Baud_Rate = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CLK_BAUD = Mhz * 1000000 / Baud_Rate;
  localparam int HALF     = CLK_BAUD / 2;
  localparam int CNT_W    = (CLK_BAUD > 2) ? $clog2(CLK_BAUD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               rx_meta_q, rx_s_q, rx_q_q;
  logic               fall_edge;

  assign fall_edge = rx_q_q & ~rx_s_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_edge) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CLK_BAUD - 1)) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Return to IDLE mid stop bit so a following start bit is not missed.
        if (cnt_q == CNT_W'(CLK_BAUD - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_q_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      rx_q_q    <= rx_s_q;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialized bit by bit, the expected
// outcome of each frame is queued, and a monitor checks every output pulse.
module tb_uart_rx;

  localparam int BIT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_busy;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses_seen = 0;
  int   pulses_exp  = 0;
  bit   saw_busy = 0;

  uart_rx #(.Mhz(1), .Baud_Rate(100000)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A frame is a start bit, eight data bits LSB first and one stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int idle_bits);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (idle_bits * BIT) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.err  = ~stop;
    e.data = d;
    exp_q.push_back(e);
    pulses_exp++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: compare each output pulse against the head of the scoreboard.
  initial begin
    logic [7:0] last_good;
    logic       prev_pulse, prev_busy;
    exp_t       e;
    last_good  = 8'h00;
    prev_pulse = 1'b0;
    prev_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) last_good = 8'h00;
      if (o_busy) saw_busy = 1;
      if (o_valid || o_frame_err) begin
        pulses_seen++;
        check("pulse_exclusive", {o_valid, o_frame_err}, {1'b1, 1'b1} & {o_valid, ~o_valid});
        check("no_double_pulse", prev_pulse, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {o_valid, o_frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_ferr", o_frame_err, e.err);
          if (e.err) begin
            check("data_held_on_ferr", o_data, last_good);
          end else begin
            check("rx_data", o_data, e.data);
            check("busy_fall_with_valid", {prev_busy, o_busy}, 2'b10);
            last_good = e.data;
          end
        end
      end
      prev_pulse = o_valid | o_frame_err;
      prev_busy  = o_busy;
    end
  end

  initial begin
    logic [7:0] d;
    logic       stop, prev_stop;
    int         idle, glen;

    repeat (3) @(negedge clk);
    check("rst_data", o_data, 8'h00);
    check("rst_valid", o_valid, 0);
    check("rst_ferr", o_frame_err, 0);
    check("rst_busy", o_busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    expect_frame(8'h55, 1'b1);
    send_frame(8'h55, 1'b1, 2);
    drain("t2_drain");
    check("t2_data", o_data, 8'h55);

    expect_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, 0);
    expect_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1, 2);
    drain("t3_drain");

    expect_frame(8'h55, 1'b1);
    send_frame(8'h55, 1'b1, 0);
    expect_frame(8'hF0, 1'b0);
    send_frame(8'hF0, 1'b0, 2);
    drain("t4_drain");
    check("t4_data_kept", o_data, 8'h55);

    for (int g = 0; g < 4; g++) begin
      glen = 1 + g;
      saw_busy = 0;
      rx = 1'b0;
      repeat (glen) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch_saw_busy", saw_busy, 1);
      check("glitch_busy_idle", o_busy, 0);
    end

    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("t6_busy_before_rst", o_busy, 1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy_after_rst", o_busy, 0);
    check("t6_data_after_rst", o_data, 8'h00);
    repeat (15 * BIT) @(negedge clk);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1, 2);
    drain("t6_drain");
    check("t6_data", o_data, 8'h81);

    prev_stop = 1'b1;
    for (int k = 0; k < 20; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      idle = $urandom_range(0, 2);
      if (!stop && idle == 0) idle = 1;
      expect_frame(d, stop);
      send_frame(d, stop, idle);
      prev_stop = stop;
    end
    rx = 1'b1;
    drain("rand_drain");
    repeat (3 * BIT) @(negedge clk);
    check("pulse_count", pulses_seen, pulses_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
